// File: rtl/route_compute_unit.sv
// route_compute_unit
//   Registered per-input route computation for a 2D mesh router. Each input
//   channel latches the destination of a head flit, computes the output port
//   (dimension-ordered XY or YX) and holds it until the packet's tail flit is
//   consumed. Packets addressed outside the mesh, or that would leave through
//   the port they arrived on, are sunk without ever presenting a route.
//
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     flit_valid     per-channel flit present
//     flit_is_head   per-channel head marker
//     flit_is_tail   per-channel tail marker (head+tail = single-flit packet)
//     dest_address   per-channel destination {y,x}, slice [i*AW +: AW]
//     route_ack      per-channel allocator accept
//     flit_ready     per-channel flit consumed (with flit_valid)
//     route_valid    per-channel route locked and valid
//     route_port     per-channel output port ID, slice [i*3 +: 3]
//     drop_active    per-channel sinking a dropped packet
//     err_orphan     per-channel sticky: non-head flit seen with no route
//
//   Channel FSM states:
//     state  | meaning
//     IDLE   | no packet; waiting for a head flit (head is not consumed here)
//     ROUTED | route locked; flits leave on allocator acks until the tail
//     DROP   | packet rejected; flits sunk one per cycle until the tail

module route_compute_unit #(
  parameter int NOC_WIDTH    = 4,
  parameter int NOC_LENGTH   = 4,
  parameter int ROUTER_ID    = 0,
  parameter int NUM_PORTS    = 5,
  parameter int ROUTING_MODE = 0,
  localparam int XW = $clog2(NOC_WIDTH),
  localparam int YW = $clog2(NOC_LENGTH),
  localparam int AW = XW + YW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   flit_valid,
  input  logic [NUM_PORTS-1:0]   flit_is_head,
  input  logic [NUM_PORTS-1:0]   flit_is_tail,
  input  logic [NUM_PORTS*AW-1:0] dest_address,
  input  logic [NUM_PORTS-1:0]   route_ack,
  output logic [NUM_PORTS-1:0]   flit_ready,
  output logic [NUM_PORTS-1:0]   route_valid,
  output logic [NUM_PORTS*3-1:0] route_port,
  output logic [NUM_PORTS-1:0]   drop_active,
  output logic [NUM_PORTS-1:0]   err_orphan
);

  localparam logic [2:0] LOCAL_PORT_ID = 3'd0;
  localparam logic [2:0] WEST_PORT_ID  = 3'd1;
  localparam logic [2:0] NORTH_PORT_ID = 3'd2;
  localparam logic [2:0] EAST_PORT_ID  = 3'd3;
  localparam logic [2:0] SOUTH_PORT_ID = 3'd4;

  localparam logic [AW-1:0] RID = AW'(ROUTER_ID);
  localparam logic [XW-1:0] RX  = RID[XW-1:0];
  localparam logic [YW-1:0] RY  = RID[AW-1:XW];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTED = 2'd1,
    DROP   = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   dest;
    logic [XW-1:0]   dx;
    logic [YW-1:0]   dy;
    logic [2:0]      port_calc;
    logic            drop_calc;
    logic [2:0]      port_q;
    logic            orphan_q;
    logic            orphan_set;
    logic            ready;
    logic            head_seen;

    assign dest = dest_address[i*AW +: AW];
    assign dx   = dest[XW-1:0];
    assign dy   = dest[AW-1:XW];

    // Dimension-ordered port selection plus the reject conditions.
    always_comb begin
      port_calc = LOCAL_PORT_ID;
      if (dest == RID) begin
        port_calc = LOCAL_PORT_ID;
      end else if (ROUTING_MODE == 0) begin
        if (dx > RX)      port_calc = EAST_PORT_ID;
        else if (dx < RX) port_calc = WEST_PORT_ID;
        else if (dy > RY) port_calc = NORTH_PORT_ID;
        else              port_calc = SOUTH_PORT_ID;
      end else begin
        if (dy > RY)      port_calc = NORTH_PORT_ID;
        else if (dy < RY) port_calc = SOUTH_PORT_ID;
        else if (dx > RX) port_calc = EAST_PORT_ID;
        else              port_calc = WEST_PORT_ID;
      end
      // A packet from any network channel must not be sent back out the
      // same side; the local channel is exempt since LOCAL is never a U-turn.
      drop_calc = (int'(dx) >= NOC_WIDTH) || (int'(dy) >= NOC_LENGTH) ||
                  ((i != 0) && (port_calc == 3'(i)));
    end

    always_comb begin
      state_next = state;
      ready      = 1'b0;
      orphan_set = 1'b0;
      head_seen  = 1'b0;
      case (state)
        IDLE: begin
          if (flit_valid[i]) begin
            if (flit_is_head[i]) begin
              // Head stays in the buffer; it is consumed in ROUTED/DROP.
              head_seen  = 1'b1;
              state_next = drop_calc ? DROP : ROUTED;
            end else begin
              ready      = 1'b1;
              orphan_set = 1'b1;
            end
          end
        end
        ROUTED: begin
          ready = flit_valid[i] & route_ack[i];
          if (ready && flit_is_tail[i]) state_next = IDLE;
        end
        DROP: begin
          ready = flit_valid[i];
          if (ready && flit_is_tail[i]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        port_q   <= 3'd0;
        orphan_q <= 1'b0;
      end else begin
        state <= state_next;
        if (head_seen) port_q <= drop_calc ? 3'd0 : port_calc;
        if (orphan_set) orphan_q <= 1'b1;
      end
    end

    // Ready is combinational, so it is masked while reset is held to keep
    // every output at zero during reset.
    assign flit_ready[i]         = ready & ~rst;
    assign route_valid[i]        = (state == ROUTED);
    assign drop_active[i]        = (state == DROP);
    assign route_port[i*3 +: 3]  = port_q;
    assign err_orphan[i]         = orphan_q;
  end

endmodule

// File: tb/tb_route_compute_unit.sv
module tb_route_compute_unit;
  localparam int NP = 5;
  localparam int AW = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    flit_valid, flit_is_head, flit_is_tail, route_ack;
  logic [NP*AW-1:0] dest_address;
  logic [NP-1:0]    fr [ND];
  logic [NP-1:0]    rv [ND];
  logic [NP-1:0]    da [ND];
  logic [NP-1:0]    eo [ND];
  logic [NP*3-1:0]  rp [ND];

  int n_chk = 0;
  int n_fail = 0;

  // dut 0: 4x4 id5 XY, dut 1: 4x4 id5 YX, dut 2: 3x3 id4 XY
  int cfg_w  [ND] = '{4, 4, 3};
  int cfg_l  [ND] = '{4, 4, 3};
  int cfg_id [ND] = '{5, 5, 4};
  int cfg_yx [ND] = '{0, 1, 0};

  // reference model: 0 = no packet, 1 = routed, 2 = dropping
  int   m_st [ND][NP];
  int   m_pt [ND][NP];
  logic m_eo [ND][NP];

  always #5 clk = ~clk;

  route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .NUM_PORTS(5), .ROUTING_MODE(0)) dut_xy (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_is_head(flit_is_head),
    .flit_is_tail(flit_is_tail), .dest_address(dest_address), .route_ack(route_ack),
    .flit_ready(fr[0]), .route_valid(rv[0]), .route_port(rp[0]), .drop_active(da[0]), .err_orphan(eo[0]));

  route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .NUM_PORTS(5), .ROUTING_MODE(1)) dut_yx (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_is_head(flit_is_head),
    .flit_is_tail(flit_is_tail), .dest_address(dest_address), .route_ack(route_ack),
    .flit_ready(fr[1]), .route_valid(rv[1]), .route_port(rp[1]), .drop_active(da[1]), .err_orphan(eo[1]));

  route_compute_unit #(.NOC_WIDTH(3), .NOC_LENGTH(3), .ROUTER_ID(4), .NUM_PORTS(5), .ROUTING_MODE(0)) dut_3x3 (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_is_head(flit_is_head),
    .flit_is_tail(flit_is_tail), .dest_address(dest_address), .route_ack(route_ack),
    .flit_ready(fr[2]), .route_valid(rv[2]), .route_port(rp[2]), .drop_active(da[2]), .err_orphan(eo[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flit_valid   = '0;
    flit_is_head = '0;
    flit_is_tail = '0;
    route_ack    = '0;
    dest_address = '0;
  endtask

  task automatic drive(input int ch, input logic v, input logic h, input logic t,
                       input int dest, input logic ack);
    flit_valid[ch]   = v;
    flit_is_head[ch] = h;
    flit_is_tail[ch] = t;
    route_ack[ch]    = ack;
    dest_address[ch*AW +: AW] = 4'(dest);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s d%0d route_valid", tag, d), rv[d], 0);
      chk($sformatf("%s d%0d route_port", tag, d), rp[d], 0);
      chk($sformatf("%s d%0d drop_active", tag, d), da[d], 0);
      chk($sformatf("%s d%0d err_orphan", tag, d), eo[d], 0);
      chk($sformatf("%s d%0d flit_ready", tag, d), fr[d], 0);
    end
  endtask

  // {drop, port}: dimension-ordered route from mesh coordinates
  function automatic logic [3:0] route_of(input int d, input int dest, input int ch);
    int dx = dest % 4;
    int dy = dest / 4;
    int rx = cfg_id[d] % 4;
    int ry = cfg_id[d] / 4;
    int port;
    logic drop;
    if (dest == cfg_id[d])  port = 0;
    else if (cfg_yx[d] == 0) port = (dx > rx) ? 3 : (dx < rx) ? 1 : (dy > ry) ? 2 : 4;
    else                     port = (dy > ry) ? 2 : (dy < ry) ? 4 : (dx > rx) ? 3 : 1;
    drop = (dx >= cfg_w[d]) || (dy >= cfg_l[d]) || (ch != 0 && port == ch);
    return {drop, 3'(port)};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NP; c++) begin
        m_st[d][c] = 0;
        m_pt[d][c] = 0;
        m_eo[d][c] = 1'b0;
      end
  endtask

  task automatic model_check(input int d, input int cyc);
    logic [NP-1:0]   e_fr, e_rv, e_da, e_eo;
    logic [NP*3-1:0] e_rp, mask;
    e_fr = '0; e_rv = '0; e_da = '0; e_eo = '0; e_rp = '0; mask = '0;
    for (int c = 0; c < NP; c++) begin
      case (m_st[d][c])
        0: e_fr[c] = flit_valid[c] & ~flit_is_head[c];
        1: e_fr[c] = flit_valid[c] & route_ack[c];
        default: e_fr[c] = flit_valid[c];
      endcase
      e_rv[c] = (m_st[d][c] == 1);
      e_da[c] = (m_st[d][c] == 2);
      e_eo[c] = m_eo[d][c];
      if (m_st[d][c] == 1) begin
        e_rp[c*3 +: 3] = 3'(m_pt[d][c]);
        mask[c*3 +: 3] = 3'b111;
      end
    end
    chk($sformatf("rand c%0d d%0d ready", cyc, d), fr[d], e_fr);
    chk($sformatf("rand c%0d d%0d route_valid", cyc, d), rv[d], e_rv);
    chk($sformatf("rand c%0d d%0d drop_active", cyc, d), da[d], e_da);
    chk($sformatf("rand c%0d d%0d err_orphan", cyc, d), eo[d], e_eo);
    chk($sformatf("rand c%0d d%0d route_port", cyc, d), rp[d] & mask, e_rp);
  endtask

  task automatic model_step(input int d);
    logic [3:0] r;
    for (int c = 0; c < NP; c++) begin
      case (m_st[d][c])
        0: if (flit_valid[c]) begin
             if (flit_is_head[c]) begin
               r = route_of(d, int'(dest_address[c*AW +: AW]), c);
               m_st[d][c] = r[3] ? 2 : 1;
               m_pt[d][c] = int'(r[2:0]);
             end else begin
               m_eo[d][c] = 1'b1;
             end
           end
        1: if (flit_valid[c] && route_ack[c] && flit_is_tail[c]) m_st[d][c] = 0;
        default: if (flit_valid[c] && flit_is_tail[c]) m_st[d][c] = 0;
      endcase
    end
  endtask

  initial begin
    int dests [NP];
    logic [3:0] r;
    clear_in();
    rst = 1'b1;
    #3;
    chk_all_zero("reset");
    #9;
    rst = 1'b0;
    tick();

    // single packet, XY, dest 7 -> EAST
    drive(0, 1, 1, 0, 7, 0);
    #1;
    chk("t1 head held", fr[0][0], 0);
    chk("t1 no route yet", rv[0][0], 0);
    tick();
    chk("t1 route_valid", rv[0][0], 1);
    chk("t1 port east", rp[0][2:0], 3);
    route_ack[0] = 1'b1;
    #1;
    chk("t1 head consumed", fr[0][0], 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, (k == 3), $urandom_range(0, 15), 1);
      #1;
      chk($sformatf("t1 body%0d valid", k), rv[0][0], 1);
      chk($sformatf("t1 body%0d port", k), rp[0][2:0], 3);
      chk($sformatf("t1 body%0d ready", k), fr[0][0], 1);
      tick();
    end
    clear_in();
    #1;
    chk("t1 released", rv[0][0], 0);

    // dest 13 -> NORTH
    do_reset();
    drive(0, 1, 1, 0, 13, 0);
    tick();
    chk("t2 port north", rp[0][2:0], 2);
    chk("t2 valid", rv[0][0], 1);
    route_ack[0] = 1'b1;
    tick();
    drive(0, 1, 0, 1, 0, 1);
    #1;
    chk("t2 tail ready", fr[0][0], 1);
    tick();
    clear_in();
    #1;
    chk("t2 released", rv[0][0], 0);

    // single-flit packet to self -> LOCAL, one cycle of route_valid
    do_reset();
    drive(0, 1, 1, 1, 5, 1);
    #1;
    chk("t3 head held", fr[0][0], 0);
    tick();
    chk("t3 valid", rv[0][0], 1);
    chk("t3 port local", rp[0][2:0], 0);
    chk("t3 ready", fr[0][0], 1);
    tick();
    clear_in();
    #1;
    chk("t3 one cycle only", rv[0][0], 0);
    tick();
    chk("t3 stays idle", rv[0][0], 0);

    // dest 14: XY -> EAST, YX -> NORTH
    do_reset();
    drive(0, 1, 1, 1, 14, 0);
    tick();
    chk("t4 xy valid", rv[0][0], 1);
    chk("t4 xy east", rp[0][2:0], 3);
    chk("t4 yx valid", rv[1][0], 1);
    chk("t4 yx north", rp[1][2:0], 2);

    // 3x3 out of range x=3 -> drop, 4 flits sunk without ack
    do_reset();
    drive(0, 1, 1, 0, 3, 0);
    #1;
    chk("t5 head held", fr[2][0], 0);
    tick();
    chk("t5 drop_active", da[2][0], 1);
    chk("t5 no route", rv[2][0], 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, (k == 0), (k == 3), $urandom_range(0, 15), 0);
      #1;
      chk($sformatf("t5 sink%0d ready", k), fr[2][0], 1);
      chk($sformatf("t5 sink%0d drop", k), da[2][0], 1);
      chk($sformatf("t5 sink%0d no route", k), rv[2][0], 0);
      tick();
    end
    clear_in();
    #1;
    chk("t5 drop done", da[2][0], 0);

    // U-turn from WEST, then orphan on NORTH
    do_reset();
    drive(1, 1, 1, 0, 4, 0);
    tick();
    chk("t6 uturn drop", da[0][1], 1);
    chk("t6 uturn no route", rv[0][1], 0);
    drive(1, 1, 0, 1, 4, 0);
    #1;
    chk("t6 uturn sink", fr[0][1], 1);
    tick();
    clear_in();
    #1;
    chk("t6 drop done", da[0][1], 0);
    drive(2, 1, 0, 0, 9, 0);
    #1;
    chk("t6 orphan ready", fr[0][2], 1);
    tick();
    clear_in();
    route_ack = '1;
    tick();
    tick();
    chk("t6 orphan sticky", eo[0], 5'b00100);
    chk("t6 ack without route", rv[0], 0);
    do_reset();
    chk("t6 orphan cleared", eo[0], 0);

    // all five channels at once, then reset mid-packet
    dests = '{7, 13, 4, 1, 5};
    for (int c = 0; c < NP; c++) drive(c, 1, 1, 0, dests[c], 0);
    tick();
    chk("t7 all valid", rv[0], 5'h1f);
    chk("t7 packed ports", rp[0], {3'd0, 3'd4, 3'd1, 3'd2, 3'd3});
    for (int c = 0; c < NP; c++) begin
      r = route_of(0, dests[c], c);
      chk($sformatf("t7 ch%0d port", c), rp[0][c*3 +: 3], r[2:0]);
    end
    route_ack = '1;
    tick();
    flit_is_head = '0;
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("t7 mid reset");
    rst = 1'b0;
    clear_in();
    tick();

    // randomized traffic against the reference model, all three configs
    model_reset();
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < NP; c++)
        drive(c, ($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0), $urandom_range(0, 15), ($urandom_range(0, 4) < 3));
      #1;
      if (cyc == 150) begin
        rst = 1'b1;
        #1;
        chk_all_zero("rand mid reset");
        rst = 1'b0;
        model_reset();
        #1;
      end
      for (int d = 0; d < ND; d++) model_check(d, cyc);
      for (int d = 0; d < ND; d++) model_step(d);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
